// File: rtl/zap_wb_fifo_drain.sv
// -----------------------------------------------------------------------------
// zap_wb_fifo_drain
//   Reader end of a first-word-fall-through write-buffer FIFO. Each head entry
//   is issued as a single Wishbone B3 classic write. A bus error or a response
//   timeout drops the entry, records its address and stops draining until
//   software clears the error.
//
// Ports
//   i_clk, i_reset_n    clock (rising edge), asynchronous active-low reset
//   i_fifo_data         head entry {sel, adr, dat}, valid when i_fifo_empty_n
//   i_fifo_empty_n      FIFO holds at least one entry
//   o_fifo_ack          combinational pop, one pulse per consumed entry
//   o_wb_*              Wishbone master write port (cyc/stb/we/adr/sel/dat/cti/bte)
//   i_wb_ack, i_wb_err  slave responses
//   i_err_clr           clears the sticky error and resumes draining
//   o_err, o_err_code   sticky error flag, 01 bus error / 10 timeout
//   o_err_adr           address of the last dropped entry
//   o_beats             count of acknowledged writes (wraps)
//   o_idle              drain engine is in IDLE
// -----------------------------------------------------------------------------
module zap_wb_fifo_drain #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int TIMEOUT  = 256,
   parameter int HOLD_CYC = 1
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic [DW/8+AW+DW-1:0]     i_fifo_data,
   input  logic                      i_fifo_empty_n,
   output logic                      o_fifo_ack,
   output logic                      o_wb_cyc,
   output logic                      o_wb_stb,
   output logic                      o_wb_we,
   output logic [AW-1:0]             o_wb_adr,
   output logic [DW/8-1:0]           o_wb_sel,
   output logic [DW-1:0]             o_wb_dat,
   output logic [2:0]                o_wb_cti,
   output logic [1:0]                o_wb_bte,
   input  logic                      i_wb_ack,
   input  logic                      i_wb_err,
   input  logic                      i_err_clr,
   output logic                      o_err,
   output logic [1:0]                o_err_code,
   output logic [AW-1:0]             o_err_adr,
   output logic [15:0]               o_beats,
   output logic                      o_idle
);

   localparam int SW   = DW / 8;
   localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_HOLD,
      S_ERR
   } state_t;

   state_t          state_q, state_d;
   logic            cyc_q, cyc_d;
   logic            stb_q, stb_d;
   logic [AW-1:0]   adr_q, adr_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic [DW-1:0]   dat_q, dat_d;
   logic            err_q, err_d;
   logic [1:0]      err_code_q, err_code_d;
   logic [AW-1:0]   err_adr_q, err_adr_d;
   logic [15:0]     beats_q, beats_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            pop;
   logic            timeout_hit;

   logic [AW-1:0]   head_adr;
   logic [SW-1:0]   head_sel;
   logic [DW-1:0]   head_dat;

   assign head_dat = i_fifo_data[DW-1:0];
   assign head_adr = i_fifo_data[AW+DW-1:DW];
   assign head_sel = i_fifo_data[SW+AW+DW-1:AW+DW];

   // Timer sits at TIMEOUT-1 on the last waiting cycle; a TIMEOUT of 0 never fires.
   assign timeout_hit = (TIMEOUT != 0) && (timer_q == TW'(TLIM));

   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      stb_d      = stb_q;
      adr_d      = adr_q;
      sel_d      = sel_q;
      dat_d      = dat_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      err_adr_d  = err_adr_q;
      beats_d    = beats_q;
      timer_d    = '0;
      pop        = 1'b0;

      case (state_q)
         S_IDLE: begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            if (i_fifo_empty_n) begin
               adr_d   = head_adr;
               sel_d   = head_sel;
               dat_d   = head_dat;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            timer_d = timer_q + TW'(1);
            // Error outranks ack; a late ack on the final timer cycle still wins over timeout.
            if (i_wb_err || (!i_wb_ack && timeout_hit)) begin
               pop        = 1'b1;
               cyc_d      = 1'b0;
               stb_d      = 1'b0;
               err_d      = 1'b1;
               err_code_d = i_wb_err ? 2'b01 : 2'b10;
               err_adr_d  = adr_q;
               timer_d    = '0;
               state_d    = S_ERR;
            end else if (i_wb_ack) begin
               pop     = 1'b1;
               beats_d = beats_q + 16'd1;
               stb_d   = 1'b0;
               timer_d = '0;
               if (HOLD_CYC != 0) begin
                  state_d = S_HOLD;
               end else begin
                  cyc_d   = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end

         // One dead cycle lets the FIFO flags settle after the pop before the next load.
         S_HOLD: begin
            if (i_fifo_empty_n) begin
               adr_d   = head_adr;
               sel_d   = head_sel;
               dat_d   = head_dat;
               stb_d   = 1'b1;
               state_d = S_WAIT;
            end else begin
               cyc_d   = 1'b0;
               state_d = S_IDLE;
            end
         end

         S_ERR: begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            if (i_err_clr) begin
               err_d      = 1'b0;
               err_code_d = 2'b00;
               state_d    = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= S_IDLE;
         cyc_q      <= 1'b0;
         stb_q      <= 1'b0;
         adr_q      <= '0;
         sel_q      <= '0;
         dat_q      <= '0;
         err_q      <= 1'b0;
         err_code_q <= 2'b00;
         err_adr_q  <= '0;
         beats_q    <= 16'd0;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         cyc_q      <= cyc_d;
         stb_q      <= stb_d;
         adr_q      <= adr_d;
         sel_q      <= sel_d;
         dat_q      <= dat_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         err_adr_q  <= err_adr_d;
         beats_q    <= beats_d;
         timer_q    <= timer_d;
      end
   end

   assign o_fifo_ack = pop;
   assign o_wb_cyc   = cyc_q;
   assign o_wb_stb   = stb_q;
   assign o_wb_we    = stb_q;
   assign o_wb_adr   = adr_q;
   assign o_wb_sel   = sel_q;
   assign o_wb_dat   = dat_q;
   assign o_wb_cti   = stb_q ? 3'b111 : 3'b000;
   assign o_wb_bte   = 2'b00;
   assign o_err      = err_q;
   assign o_err_code = err_code_q;
   assign o_err_adr  = err_adr_q;
   assign o_beats    = beats_q;
   assign o_idle     = (state_q == S_IDLE);

endmodule

// File: tb/tb_zap_wb_fifo_drain.sv
module tb_zap_wb_fifo_drain;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   // Slave response modes: 0 ack, 1 err, 2 ack+err together, 3 never respond.
   typedef struct packed {
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [1:0]  mode;
      logic [3:0]  dly;
   } ent_t;

   typedef struct packed {
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic [7:0]  stb_len;
   } exp_t;

   typedef struct packed {
      ent_t        e;
      logic [15:0] beats;
      logic [1:0]  code;
   } vec_t;

   logic          clk;
   logic          rst_n;
   logic [67:0]   fifo_data;
   logic          fifo_empty_n;
   logic          fifo_ack;
   logic          wb_cyc, wb_stb, wb_we;
   logic [31:0]   wb_adr;
   logic [3:0]    wb_sel;
   logic [31:0]   wb_dat;
   logic [2:0]    wb_cti;
   logic [1:0]    wb_bte;
   logic          wb_ack, wb_err;
   logic          err_clr;
   logic          err;
   logic [1:0]    err_code;
   logic [31:0]   err_adr;
   logic [15:0]   beats;
   logic          idle;

   ent_t          fifo_m[$];
   exp_t          exp_q[$];
   int            n_chk;
   int            n_fail;
   int            stb_run;
   logic          pop_pending;
   logic          stray_ack;
   vec_t          tab[7];

   zap_wb_fifo_drain #(.AW(AW), .DW(DW), .TIMEOUT(TO), .HOLD_CYC(1)) dut (
      .i_clk          (clk),
      .i_reset_n      (rst_n),
      .i_fifo_data    (fifo_data),
      .i_fifo_empty_n (fifo_empty_n),
      .o_fifo_ack     (fifo_ack),
      .o_wb_cyc       (wb_cyc),
      .o_wb_stb       (wb_stb),
      .o_wb_we        (wb_we),
      .o_wb_adr       (wb_adr),
      .o_wb_sel       (wb_sel),
      .o_wb_dat       (wb_dat),
      .o_wb_cti       (wb_cti),
      .o_wb_bte       (wb_bte),
      .i_wb_ack       (wb_ack),
      .i_wb_err       (wb_err),
      .i_err_clr      (err_clr),
      .o_err          (err),
      .o_err_code     (err_code),
      .o_err_adr      (err_adr),
      .o_beats        (beats),
      .o_idle         (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_fifo();
      if (fifo_m.size() > 0) begin
         fifo_data    = {fifo_m[0].sel, fifo_m[0].adr, fifo_m[0].dat};
         fifo_empty_n = 1'b1;
      end else begin
         fifo_data    = '0;
         fifo_empty_n = 1'b0;
      end
   endtask

   task automatic push_entry(input ent_t e);
      exp_t x;
      x.adr     = e.adr;
      x.sel     = e.sel;
      x.dat     = e.dat;
      x.stb_len = (e.mode == 2'd3) ? 8'(TO) : 8'(e.dly) + 8'd1;
      fifo_m.push_back(e);
      exp_q.push_back(x);
      drive_fifo();
   endtask

   // One clock: apply last pop and slave response after the edge, sample at negedge.
   task automatic cycle();
      logic fire;
      exp_t x;
      @(posedge clk);
      #1;
      if (pop_pending) begin
         if (fifo_m.size() > 0) fifo_m.delete(0);
         pop_pending = 1'b0;
         drive_fifo();
      end
      wb_ack = stray_ack;
      wb_err = 1'b0;
      if (wb_stb && fifo_m.size() > 0) begin
         fire   = (fifo_m[0].mode != 2'd3) && (stb_run >= int'(fifo_m[0].dly));
         wb_ack = stray_ack | (fire && (fifo_m[0].mode == 2'd0 || fifo_m[0].mode == 2'd2));
         wb_err = fire && (fifo_m[0].mode == 2'd1 || fifo_m[0].mode == 2'd2);
      end
      @(negedge clk);
      if (wb_stb) stb_run++;
      if (fifo_ack) begin
         chk("pop_nonempty", 64'(fifo_empty_n), 64'd1);
         if (exp_q.size() == 0) begin
            chk("pop_expected", 64'(exp_q.size()), 64'd1);
         end else begin
            x = exp_q.pop_front();
            chk("pop_adr", 64'(wb_adr), 64'(x.adr));
            chk("pop_sel_dat", {28'd0, wb_sel, wb_dat}, {28'd0, x.sel, x.dat});
            chk("pop_we_cti_bte", {58'd0, wb_we, wb_cti, wb_bte}, 64'b111100);
            chk("pop_stb_len", 64'(stb_run), 64'(x.stb_len));
         end
         pop_pending = 1'b1;
         stb_run     = 0;
      end
   endtask

   task automatic run_until_done(input string name, input int bound);
      int  n;
      logic done;
      n    = 0;
      done = 1'b0;
      while (!done && n < bound) begin
         cycle();
         n++;
         done = err || (idle && fifo_m.size() == 0);
      end
      chk({name, "_done"}, 64'(done), 64'd1);
   endtask

   task automatic clear_err(input string name, input logic [31:0] kept_adr);
      err_clr = 1'b1;
      cycle();
      err_clr = 1'b0;
      chk({name, "_clr_err"}, {61'd0, err, err_code}, 64'd0);
      chk({name, "_clr_idle"}, 64'(idle), 64'd1);
      chk({name, "_clr_adr_kept"}, 64'(err_adr), 64'(kept_adr));
   endtask

   initial begin
      int          cyc_n;
      logic [5:0]  trace;
      int          stb_cnt;
      logic        done;

      n_chk       = 0;
      n_fail      = 0;
      stb_run     = 0;
      pop_pending = 1'b0;
      stray_ack   = 1'b0;
      rst_n       = 1'b0;
      wb_ack      = 1'b0;
      wb_err      = 1'b0;
      err_clr     = 1'b0;
      drive_fifo();

      //           sel    adr       dat           mode dly    beats  code
      tab[0] = '{'{4'hF, 32'h100, 32'hDEADBEEF, 2'd0, 4'd1}, 16'd1, 2'b00};
      tab[1] = '{'{4'h3, 32'h200, 32'h12345678, 2'd0, 4'd0}, 16'd2, 2'b00};
      tab[2] = '{'{4'hC, 32'h300, 32'hA5A5A5A5, 2'd1, 4'd2}, 16'd2, 2'b01};
      tab[3] = '{'{4'h1, 32'h400, 32'h00000000, 2'd0, 4'd3}, 16'd3, 2'b00};
      tab[4] = '{'{4'h8, 32'h500, 32'hFFFFFFFF, 2'd2, 4'd0}, 16'd3, 2'b01};
      tab[5] = '{'{4'hF, 32'h600, 32'hCAFEF00D, 2'd3, 4'd0}, 16'd3, 2'b10};
      tab[6] = '{'{4'hF, 32'h700, 32'h00000001, 2'd0, 4'd7}, 16'd4, 2'b00};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_wb", {30'd0, wb_cyc, wb_stb, wb_adr}, 64'd0);
      chk("rst_err", {29'd0, err, err_code, err_adr}, 64'd0);
      chk("rst_beats_idle", {47'd0, beats, idle}, 64'd1);
      chk("rst_fifo_ack", 64'(fifo_ack), 64'd0);
      rst_n = 1'b1;

      // Single entries with varied slave behaviour
      for (int i = 0; i < 7; i++) begin
         push_entry(tab[i].e);
         run_until_done($sformatf("row%0d", i), 40);
         chk($sformatf("row%0d_beats", i), 64'(beats), 64'(tab[i].beats));
         chk($sformatf("row%0d_code", i), {62'd0, err_code}, {62'd0, tab[i].code});
         if (tab[i].code != 2'b00) begin
            chk($sformatf("row%0d_err_adr", i), 64'(err_adr), 64'(tab[i].e.adr));
            chk($sformatf("row%0d_err_cyc", i), {62'd0, wb_cyc, err}, 64'd1);
            clear_err($sformatf("row%0d", i), tab[i].e.adr);
         end
      end

      // Zero-wait stream of three: cyc held, stb every other cycle
      push_entry('{4'hF, 32'h100, 32'h11111111, 2'd0, 4'd0});
      push_entry('{4'hF, 32'h104, 32'h22222222, 2'd0, 4'd0});
      push_entry('{4'hF, 32'h108, 32'h33333333, 2'd0, 4'd0});
      cyc_n = 0;
      trace = '0;
      done  = 1'b0;
      for (int k = 0; k < 30 && !done; k++) begin
         cycle();
         if (wb_cyc) begin
            cyc_n++;
            trace = {trace[4:0], wb_stb};
         end
         done = idle && fifo_m.size() == 0;
      end
      chk("stream_done", 64'(done), 64'd1);
      chk("stream_cyc_len", 64'(cyc_n), 64'd6);
      chk("stream_stb_pattern", 64'(trace), 64'b101010);
      chk("stream_beats", 64'(beats), 64'd7);

      // Error on the middle write stalls the third
      push_entry('{4'hF, 32'h100, 32'h0000AAAA, 2'd0, 4'd0});
      push_entry('{4'hF, 32'h104, 32'h0000BBBB, 2'd1, 4'd0});
      push_entry('{4'hF, 32'h108, 32'h0000CCCC, 2'd0, 4'd0});
      run_until_done("mid_err", 40);
      chk("mid_err_flag", {61'd0, err, err_code}, 64'b101);
      chk("mid_err_adr", 64'(err_adr), 64'h104);
      chk("mid_err_beats", 64'(beats), 64'd8);
      stb_cnt = 0;
      repeat (5) begin
         cycle();
         if (wb_stb || wb_cyc) stb_cnt++;
      end
      chk("mid_err_stalled", 64'(stb_cnt), 64'd0);
      chk("mid_err_left", 64'(fifo_m.size()), 64'd1);
      clear_err("mid_err", 32'h104);
      run_until_done("mid_err_resume", 40);
      chk("mid_err_resume_beats", 64'(beats), 64'd9);
      chk("mid_err_all_popped", 64'(exp_q.size()), 64'd0);

      // Stray acks while idle are ignored
      stray_ack = 1'b1;
      repeat (3) cycle();
      stray_ack = 1'b0;
      chk("stray_ack_beats", 64'(beats), 64'd9);
      chk("stray_ack_idle", 64'(idle), 64'd1);

      // Asynchronous reset in the middle of a wait
      push_entry('{4'hF, 32'h900, 32'h99999999, 2'd3, 4'd0});
      repeat (3) cycle();
      chk("pre_rst_stb", {62'd0, wb_cyc, wb_stb}, 64'b11);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_wb", {30'd0, wb_cyc, wb_stb, wb_adr}, 64'd0);
      chk("async_rst_state", {45'd0, beats, idle, err, fifo_ack}, 64'b100);
      chk("async_rst_err_adr", 64'(err_adr), 64'd0);
      chk("async_rst_no_pop", 64'(fifo_m.size()), 64'd1);
      fifo_m.delete();
      exp_q.delete();
      drive_fifo();
      stb_run     = 0;
      pop_pending = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) cycle();
      chk("post_rst_idle", {47'd0, beats, idle}, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
